muldiv_seq: RTL

Iterative multiply/divide sequencer for the execute stage. It owns the HI/LO architectural registers and sequences a shared radix-2 shift-add/shift-subtract datapath over WIDTH cycles for MULT/MULTU/DIV/DIVU. It also performs single-cycle MTHI/MTLO writes. Hazard logic stalls the pipeline on `o_busy` so that MFHI/MFLO and new mul/div ops wait until the result is ready.

---
 rtl/muldiv_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide sequencer that owns the HI/LO registers.
// Define MULDIV_DIV_EN to include the restoring divide path (DIV/DIVU); otherwise those ops are ignored.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [2*WIDTH-1:0]   acc_r, acc_nxt_s, prod_s;
    logic [WIDTH-1:0]     opnd_r;
    logic [CW-1:0]        cnt_r;
    logic                 neg_r;
    logic [WIDTH-1:0]     hi_r, lo_r, hi_nxt_s, lo_nxt_s;
    logic                 done_r;
    logic                 issue_s, signed_s, mul_op_s, div_op_s, run_op_s;
    logic [WIDTH:0]       mul_sum_s;
`ifdef MULDIV_DIV_EN
    logic                 is_div_r, neg_rem_r, div0_op_r, div0_r;
    logic [WIDTH-1:0]     dividend_r;
    logic [WIDTH:0]       div_shift_s, div_diff_s;
    logic                 div_ge_s;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    // Issue decode: only a clean start in IDLE is accepted
    always_comb begin
        issue_s  = i_start & ~i_flush & (state_r == IDLE);
        signed_s = ~i_op[0];
        mul_op_s = (i_op == OP_MULT) || (i_op == OP_MULTU);
`ifdef MULDIV_DIV_EN
        div_op_s = (i_op == OP_DIV) || (i_op == OP_DIVU);
`else
        div_op_s = 1'b0;
`endif
        run_op_s = issue_s & (mul_op_s | div_op_s);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (run_op_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (i_flush) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = FIXUP;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIXUP:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        // Remainder stays below the divisor, so the borrow bit alone decides the compare
        div_ge_s    = ~div_diff_s[WIDTH];
        if (is_div_r) begin
            acc_nxt_s = {(div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0]),
                         acc_r[WIDTH-2:0], div_ge_s};
        end else begin
            acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
`endif
    end

    // Sign fix-up and HI/LO result mapping
    always_comb begin
        prod_s   = neg_r ? (-acc_r) : acc_r;
        hi_nxt_s = prod_s[2*WIDTH-1:WIDTH];
        lo_nxt_s = prod_s[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_r) begin
            if (div0_op_r) begin
                lo_nxt_s = '1;
                hi_nxt_s = dividend_r;
            end else begin
                lo_nxt_s = neg_r ? (-acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
                hi_nxt_s = neg_rem_r ? (-acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            end
        end else begin
            hi_nxt_s = prod_s[2*WIDTH-1:WIDTH];
            lo_nxt_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // Operand latch, iteration counter, HI/LO writeback and done pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r      <= '0;
            opnd_r     <= '0;
            cnt_r      <= '0;
            neg_r      <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
            done_r     <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_r   <= 1'b0;
            neg_rem_r  <= 1'b0;
            div0_op_r  <= 1'b0;
            div0_r     <= 1'b0;
            dividend_r <= '0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MULDIV_DIV_EN
            div0_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (run_op_s) begin
                        cnt_r <= '0;
                        neg_r <= signed_s & (i_src1[WIDTH-1] ^ i_src2[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        is_div_r   <= div_op_s;
                        neg_rem_r  <= signed_s & i_src1[WIDTH-1];
                        div0_op_r  <= (i_src2 == '0);
                        dividend_r <= i_src1;
                        if (div_op_s) begin
                            acc_r  <= {{WIDTH{1'b0}}, magnitude(i_src1, signed_s)};
                            opnd_r <= magnitude(i_src2, signed_s);
                        end else begin
                            acc_r  <= {{WIDTH{1'b0}}, magnitude(i_src2, signed_s)};
                            opnd_r <= magnitude(i_src1, signed_s);
                        end
`else
                        acc_r  <= {{WIDTH{1'b0}}, magnitude(i_src2, signed_s)};
                        opnd_r <= magnitude(i_src1, signed_s);
`endif
                    end else if (issue_s && (i_op == OP_MTHI)) begin
                        hi_r <= i_src1;
                    end else if (issue_s && (i_op == OP_MTLO)) begin
                        lo_r <= i_src1;
                    end
                end
                RUN: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                FIXUP: begin
                    if (!i_flush) begin
                        hi_r   <= hi_nxt_s;
                        lo_r   <= lo_nxt_s;
                        done_r <= 1'b1;
`ifdef MULDIV_DIV_EN
                        div0_r <= is_div_r & div0_op_r;
`endif
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = (state_r != IDLE);
    assign o_done = done_r;
    assign o_hi   = hi_r;
    assign o_lo   = lo_r;
`ifdef MULDIV_DIV_EN
    assign o_div0 = div0_r;
`else
    assign o_div0 = 1'b0;
`endif

endmodule
